// File: rtl/connect4_turn_controller.sv
`default_nettype none
// ============================================================================
// Module : connect4_turn_controller
// Brief  : Turn sequencer for a 4x4 Connect4 board with a turn timer and win/draw detection.
// Rev    : 1.0
// ============================================================================
module connect4_turn_controller #(
  parameter int unsigned TURN_TIMEOUT = 50_000_000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        col_valid_i,
  input  logic [1:0]  col_sel_i,
  input  logic [15:0] gameboard_i,
  input  logic [15:0] players_cells_i,
  output logic        col_ready_o,
  output logic [1:0]  state_o,
  output logic [4:0]  column_pos_o,
  output logic        move_reject_o,
  output logic        timeout_o,
  output logic [1:0]  winner_o,
  output logic [4:0]  move_count_o
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RESTART   = 4'd1,
    P1_WAIT   = 4'd2,
    P1_COMMIT = 4'd3,
    P1_CHECK  = 4'd4,
    P2_WAIT   = 4'd5,
    P2_COMMIT = 4'd6,
    P2_CHECK  = 4'd7,
    END       = 4'd8
  } fsm_e;

  localparam logic             TIMER_EN   = (TURN_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TIMER_LAST = TIMER_EN ? CNT_W'(TURN_TIMEOUT - 1) : '0;
  localparam logic [4:0]       NO_WRITE   = 5'h1F;

  fsm_e             fsm_q, fsm_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       cell_q, cell_d;
  logic [1:0]       state_q, state_d;
  logic [4:0]       pos_q, pos_d;
  logic             ready_q, ready_d;
  logic             reject_q, reject_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       winner_q, winner_d;
  logic [4:0]       count_q, count_d;

  logic             p2_turn;
  logic [15:0]      owned;
  logic             col_full;
  logic [1:0]       drop_row;

  function automatic logic has_line(input logic [15:0] o);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (&o[4*i +: 4]) hit = 1'b1;
      if (o[i] && o[i+4] && o[i+8] && o[i+12]) hit = 1'b1;
    end
    if (o[0] && o[5] && o[10] && o[15]) hit = 1'b1;
    if (o[3] && o[6] && o[9]  && o[12]) hit = 1'b1;
    return hit;
  endfunction

  always_comb begin
    fsm_d     = fsm_q;
    timer_d   = timer_q;
    cell_d    = cell_q;
    winner_d  = winner_q;
    count_d   = count_q;
    reject_d  = 1'b0;
    timeout_d = 1'b0;

    p2_turn  = (fsm_q == P2_WAIT) || (fsm_q == P2_COMMIT) || (fsm_q == P2_CHECK);
    owned    = gameboard_i & (p2_turn ? players_cells_i : ~players_cells_i);
    col_full = gameboard_i[{2'b11, col_sel_i}];

    // Scan downward so the last hit is the lowest empty row
    drop_row = 2'd3;
    for (int r = 3; r >= 0; r--) begin
      if (!gameboard_i[{r[1:0], col_sel_i}]) drop_row = r[1:0];
    end

    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          fsm_d    = P1_WAIT;
          timer_d  = '0;
          winner_d = 2'b00;
          count_d  = 5'd0;
        end
      end
      RESTART: fsm_d = P1_WAIT;
      P1_WAIT, P2_WAIT: begin
        if (col_valid_i && !col_full) begin
          fsm_d   = p2_turn ? P2_COMMIT : P1_COMMIT;
          cell_d  = {drop_row, col_sel_i};
          timer_d = '0;
          count_d = (count_q == 5'd16) ? count_q : count_q + 5'd1;
        end else begin
          reject_d = col_valid_i;
          if (TIMER_EN && (timer_q == TIMER_LAST)) begin
            timeout_d = 1'b1;
            timer_d   = '0;
            fsm_d     = p2_turn ? P1_WAIT : P2_WAIT;
          end else begin
            timer_d = TIMER_EN ? timer_q + CNT_W'(1) : '0;
          end
        end
      end
      P1_COMMIT: fsm_d = P1_CHECK;
      P2_COMMIT: fsm_d = P2_CHECK;
      P1_CHECK, P2_CHECK: begin
        if (has_line(owned)) begin
          winner_d = p2_turn ? 2'b10 : 2'b01;
          fsm_d    = END;
        end else if (count_q == 5'd16) begin
          winner_d = 2'b11;
          fsm_d    = END;
        end else begin
          timer_d = '0;
          fsm_d   = p2_turn ? P1_WAIT : P2_WAIT;
        end
      end
      END:     fsm_d = END;
      default: fsm_d = IDLE;
    endcase

    // A new-game request overrides whatever the current state decided
    if (start_i && (fsm_q != IDLE)) begin
      fsm_d     = RESTART;
      reject_d  = 1'b0;
      timeout_d = 1'b0;
      winner_d  = 2'b00;
      count_d   = 5'd0;
      timer_d   = '0;
    end

    state_d = 2'b00;
    ready_d = 1'b0;
    pos_d   = NO_WRITE;
    case (fsm_d)
      P1_WAIT:   begin state_d = 2'b01; ready_d = 1'b1; end
      P1_COMMIT: begin state_d = 2'b01; pos_d = {1'b0, cell_d}; end
      P1_CHECK:  state_d = 2'b01;
      P2_WAIT:   begin state_d = 2'b10; ready_d = 1'b1; end
      P2_COMMIT: begin state_d = 2'b10; pos_d = {1'b0, cell_d}; end
      P2_CHECK:  state_d = 2'b10;
      END:       state_d = 2'b11;
      default:   state_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      timer_q   <= '0;
      cell_q    <= 4'd0;
      state_q   <= 2'b00;
      pos_q     <= NO_WRITE;
      ready_q   <= 1'b0;
      reject_q  <= 1'b0;
      timeout_q <= 1'b0;
      winner_q  <= 2'b00;
      count_q   <= 5'd0;
    end else begin
      fsm_q     <= fsm_d;
      timer_q   <= timer_d;
      cell_q    <= cell_d;
      state_q   <= state_d;
      pos_q     <= pos_d;
      ready_q   <= ready_d;
      reject_q  <= reject_d;
      timeout_q <= timeout_d;
      winner_q  <= winner_d;
      count_q   <= count_d;
    end
  end

  assign col_ready_o   = ready_q;
  assign state_o       = state_q;
  assign column_pos_o  = pos_q;
  assign move_reject_o = reject_q;
  assign timeout_o     = timeout_q;
  assign winner_o      = winner_q;
  assign move_count_o  = count_q;

endmodule
`default_nettype wire
